// File: rtl/coinc_pkg.sv
// Shared types and elaboration helpers for the gated coincidence counter.
// Pair numbering is lexicographic: (0,1),(0,2)..(0,N-1),(1,2)..
package coinc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    function automatic int npairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/coinc_chan_front.sv
// Per-channel front end: registered rising-edge extraction, tapped delay line
// and a retriggerable coincidence-window down-counter.
module coinc_chan_front #(
    parameter int NBITS = 4,
    parameter int WBITS = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             channel,
    input  logic [NBITS-1:0] delay,
    input  logic [WBITS-1:0] window,
    output logic             d,
    output logic             armed
);

    localparam int DEPTH = 2**NBITS - 1;

    logic             prev_p0;
    logic             edge_p0;
    logic [DEPTH-1:0] line_p1;
    logic [WBITS-1:0] win_cnt;

    // stage 0: edge register; stage 1: delay line fed by the edge pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_p0 <= 1'b0;
            edge_p0 <= 1'b0;
            line_p1 <= '0;
        end else begin
            prev_p0 <= channel;
            edge_p0 <= channel & ~prev_p0;
            line_p1 <= (line_p1 << 1) | DEPTH'(edge_p0);
        end
    end

    always_comb begin
        d = edge_p0;
        if (delay != '0) d = line_p1[delay - NBITS'(1)];
    end

    // armed reflects the counter before this cycle's reload
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            win_cnt <= '0;
        end else if (d) begin
            win_cnt <= window;
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    assign armed = (win_cnt != '0);

endmodule

// File: rtl/coincidence_counter_gated.sv
// Gated multi-channel coincidence counter: counts pair coincidences and singles
// over back-to-back integration periods and publishes a snapshot at each end.
module coincidence_counter_gated
    import coinc_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int NBITS = 4,
    parameter int CBITS = 16,
    parameter int WBITS = 3,
    parameter int TBITS = 24,
    localparam int NPAIRS = npairs(NCHAN)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NCHAN-1:0]        Channels,
    input  logic [NCHAN*NBITS-1:0]  Delays,
    input  logic [WBITS-1:0]        Window,
    input  logic [TBITS-1:0]        Period,
    input  logic                    Start,
    input  logic                    Stop,
    output logic [NPAIRS*CBITS-1:0] Counts,
    output logic [NCHAN*CBITS-1:0]  Singles,
    output logic [NPAIRS-1:0]       Overflow,
    output logic                    Counts_valid,
    output logic                    Busy
);

    localparam logic [CBITS-1:0] CMAX = '1;

    state_t            state, next_state;
    logic [TBITS-1:0]  timer;
    logic [NCHAN-1:0]  d, armed;
    logic [NPAIRS-1:0] coinc, ovf, lost;
    logic [CBITS-1:0]  pair_cnt [NPAIRS];
    logic [CBITS-1:0]  pair_next [NPAIRS];
    logic [CBITS-1:0]  single_cnt [NCHAN];
    logic [CBITS-1:0]  single_next [NCHAN];
    logic              counting, period_end, load_start;

    function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v, input logic inc);
        return (inc && v != CMAX) ? v + 1'b1 : v;
    endfunction

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        coinc_chan_front #(.NBITS(NBITS), .WBITS(WBITS)) u_front (
            .Clk     (Clk),
            .Rst_n   (Rst_n),
            .channel (Channels[c]),
            .delay   (Delays[c*NBITS +: NBITS]),
            .window  (Window),
            .d       (d[c]),
            .armed   (armed[c])
        );
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_row
        for (genvar j = i + 1; j < NCHAN; j++) begin : g_col
            localparam int K = pair_index(i, j, NCHAN);
            assign coinc[K] = (d[i] & (d[j] | armed[j])) | (d[j] & armed[i]);
        end
    end

    always_comb begin
        for (int k = 0; k < NPAIRS; k++) begin
            pair_next[k] = sat_inc(pair_cnt[k], coinc[k]);
            lost[k]      = coinc[k] & (pair_cnt[k] == CMAX);
        end
        for (int c = 0; c < NCHAN; c++) begin
            single_next[c] = sat_inc(single_cnt[c], d[c]);
        end
    end

    always_comb begin
        next_state = state;
        counting   = (state != IDLE);
        period_end = counting && (timer == TBITS'(1));
        load_start = 1'b0;
        unique case (state)
            IDLE: if (Start && Period != '0) begin
                next_state = RUN;
                load_start = 1'b1;
            end
            RUN:  if (Stop) next_state = LAST;
            LAST: if (period_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            Busy         <= 1'b0;
            Counts_valid <= 1'b0;
        end else begin
            state        <= next_state;
            Busy         <= (next_state != IDLE);
            Counts_valid <= period_end;
            if (load_start || period_end) timer <= Period;
            else if (counting)            timer <= timer - 1'b1;
        end
    end

    // running counters restart at every period boundary
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < NPAIRS; k++) pair_cnt[k] <= '0;
            for (int c = 0; c < NCHAN; c++)  single_cnt[c] <= '0;
            ovf <= '0;
        end else if (load_start || period_end) begin
            for (int k = 0; k < NPAIRS; k++) pair_cnt[k] <= '0;
            for (int c = 0; c < NCHAN; c++)  single_cnt[c] <= '0;
            ovf <= '0;
        end else if (counting) begin
            for (int k = 0; k < NPAIRS; k++) pair_cnt[k] <= pair_next[k];
            for (int c = 0; c < NCHAN; c++)  single_cnt[c] <= single_next[c];
            ovf <= ovf | lost;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Counts   <= '0;
            Singles  <= '0;
            Overflow <= '0;
        end else if (period_end) begin
            for (int k = 0; k < NPAIRS; k++) Counts[k*CBITS +: CBITS] <= pair_next[k];
            for (int c = 0; c < NCHAN; c++)  Singles[c*CBITS +: CBITS] <= single_next[c];
            Overflow <= ovf | lost;
        end
    end

endmodule

// File: tb/tb_coincidence_counter_gated.sv
// Randomised and directed bench for coincidence_counter_gated with an
// event-time reference model checked every cycle.
module tb_coincidence_counter_gated;

    localparam int NCHAN  = 4;
    localparam int NBITS  = 4;
    localparam int CBITS  = 8;
    localparam int WBITS  = 3;
    localparam int TBITS  = 12;
    localparam int NPAIRS = 6;

    logic                    Clk = 1'b0;
    logic                    Rst_n;
    logic [NCHAN-1:0]        Channels;
    logic [NCHAN*NBITS-1:0]  Delays;
    logic [WBITS-1:0]        Window;
    logic [TBITS-1:0]        Period;
    logic                    Start, Stop;
    logic [NPAIRS*CBITS-1:0] Counts;
    logic [NCHAN*CBITS-1:0]  Singles;
    logic [NPAIRS-1:0]       Overflow;
    logic                    Counts_valid, Busy;

    coincidence_counter_gated #(
        .NCHAN(NCHAN), .NBITS(NBITS), .CBITS(CBITS), .WBITS(WBITS), .TBITS(TBITS)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Channels(Channels), .Delays(Delays),
        .Window(Window), .Period(Period), .Start(Start), .Stop(Stop),
        .Counts(Counts), .Singles(Singles), .Overflow(Overflow),
        .Counts_valid(Counts_valid), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: events are tracked as times (edge indices), not as hardware state.
    int pa[NPAIRS], pb[NPAIRS];
    int m_state;            // 0 idle, 1 run, 2 last
    int m_timer, m_n;
    int m_pc[NPAIRS], m_sc[NCHAN];
    bit m_ovf[NPAIRS];
    bit m_prev[NCHAN];
    bit m_fut[NCHAN][64];   // detection events scheduled at their counting edge
    bit m_hist[NCHAN][64];  // delayed events that occurred at each past edge
    logic [NPAIRS*CBITS-1:0] e_counts;
    logic [NCHAN*CBITS-1:0]  e_singles;
    logic [NPAIRS-1:0]       e_ovf;
    logic                    e_valid, e_busy;

    function automatic void model_clear_counts();
        for (int k = 0; k < NPAIRS; k++) begin m_pc[k] = 0; m_ovf[k] = 0; end
        for (int c = 0; c < NCHAN; c++) m_sc[c] = 0;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_timer = 0; m_n = 0;
        model_clear_counts();
        for (int c = 0; c < NCHAN; c++) begin
            m_prev[c] = 0;
            for (int t = 0; t < 64; t++) begin m_fut[c][t] = 0; m_hist[c][t] = 0; end
        end
        e_counts = '0; e_singles = '0; e_ovf = '0; e_valid = 0; e_busy = 0;
    endfunction

    function automatic bit recent(input int c, input int n, input int w);
        for (int m = 1; m <= w; m++)
            if (m_hist[c][((n - m) % 64 + 64) % 64]) return 1;
        return 0;
    endfunction

    function automatic void model_step();
        int n = m_n;
        bit dv[NCHAN];
        bit hit;
        int w = int'(Window);
        for (int c = 0; c < NCHAN; c++) begin
            dv[c] = m_fut[c][n % 64];
            m_fut[c][n % 64] = 0;
            m_hist[c][n % 64] = dv[c];
        end
        e_valid = 0;
        if (m_state != 0) begin
            for (int k = 0; k < NPAIRS; k++) begin
                hit = (dv[pa[k]] && dv[pb[k]]) || (dv[pa[k]] && recent(pb[k], n, w))
                   || (dv[pb[k]] && recent(pa[k], n, w));
                if (hit) begin
                    if (m_pc[k] == 255) m_ovf[k] = 1;
                    else m_pc[k]++;
                end
            end
            for (int c = 0; c < NCHAN; c++)
                if (dv[c] && m_sc[c] < 255) m_sc[c]++;
            if (m_timer == 1) begin
                for (int k = 0; k < NPAIRS; k++) begin
                    e_counts[k*CBITS +: CBITS] = 8'(m_pc[k]);
                    e_ovf[k] = m_ovf[k];
                end
                for (int c = 0; c < NCHAN; c++) e_singles[c*CBITS +: CBITS] = 8'(m_sc[c]);
                model_clear_counts();
                m_timer = int'(Period);
                e_valid = 1;
                if (m_state == 2) m_state = 0;
                else if (Stop)    m_state = 2;
            end else begin
                m_timer--;
                if (m_state == 1 && Stop) m_state = 2;
            end
        end else if (Start && Period != 0) begin
            m_state = 1;
            m_timer = int'(Period);
            model_clear_counts();
        end
        e_busy = (m_state != 0);
        for (int c = 0; c < NCHAN; c++) begin
            if (Channels[c] && !m_prev[c])
                m_fut[c][(n + 1 + int'(Delays[c*NBITS +: NBITS])) % 64] = 1;
            m_prev[c] = Channels[c];
        end
        m_n++;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) model_reset();
        else        model_step();
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("counts",   64'(Counts),       64'(e_counts));
            chk("singles",  64'(Singles),      64'(e_singles));
            chk("overflow", 64'(Overflow),     64'(e_ovf));
            chk("valid",    64'(Counts_valid), 64'(e_valid));
            chk("busy",     64'(Busy),         64'(e_busy));
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (Counts_valid === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no Counts_valid within %0d cycles", tag, budget);
        end
    endtask

    task automatic start_run(input int per);
        Period = TBITS'(per);
        Start = 1; tick(); Start = 0;
    endtask

    // One edge on ca (held for hold cycles) and one edge on cb gap cycles later.
    task automatic pair_run(input int ca, input int cb, input int dly, input int win,
                            input int gap, input int hold);
        Channels = '0;
        Delays = '0;
        Delays[ca*NBITS +: NBITS] = NBITS'(dly);
        Window = WBITS'(win);
        repeat (20) tick();
        start_run(30);
        Stop = 1; tick(); Stop = 0;
        tick();
        for (int t = 0; t < 12; t++) begin
            Channels = '0;
            Channels[ca] = (t < hold);
            if (gap >= 0) Channels[cb] = (t == gap);
            tick();
        end
        Channels = '0;
        wait_valid(40, "pair_run");
    endtask

    int strobes;
    bit idle_seen;

    initial begin
        k_init();
        model_reset();
        Rst_n = 0; Channels = '0; Delays = '0; Window = '0; Period = '0; Start = 0; Stop = 0;
        for (int i = 0; i < 6; i++) begin
            Channels = NCHAN'($urandom); Start = i[0]; Period = 12'd5;
            tick();
        end
        cmp_en = 1;
        chk("rst_counts", 64'(Counts), 64'd0);
        chk("rst_singles", 64'(Singles), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        Channels = '0; Start = 0;
        Rst_n = 1;
        repeat (3) tick();

        // simultaneous ch0+ch1 edges three times, one lone ch2 edge
        start_run(20);
        chk("busy_after_start", 64'(Busy), 64'd1);
        Stop = 1;
        for (int r = 0; r < 3; r++) begin
            Channels = 4'b0011; tick(); Stop = 0; Channels = '0; tick();
        end
        Channels = 4'b0100; tick(); Channels = '0;
        wait_valid(40, "basic");
        chk("basic_counts", 64'(Counts), 64'h3);
        chk("basic_singles", 64'(Singles), 64'h0001_0303);

        pair_run(0, 1, 5, 0, 5, 1);
        chk("delay5_w0", 64'(Counts), 64'h1);
        pair_run(0, 1, 4, 0, 5, 1);
        chk("delay4_w0", 64'(Counts), 64'h0);
        pair_run(0, 1, 4, 1, 5, 1);
        chk("delay4_w1", 64'(Counts), 64'h1);
        pair_run(2, 3, 0, 3, 3, 1);
        chk("win3_gap3", 64'(Counts), 64'h01_0000_0000_00);
        pair_run(2, 3, 0, 3, 4, 1);
        chk("win3_gap4", 64'(Counts), 64'h0);
        pair_run(2, 3, 0, 3, -1, 10);
        chk("held_single", 64'(Singles), 64'h0001_0000);

        // saturation, then an empty period clears the flags
        Delays = '0; Window = '0; Channels = '0;
        repeat (20) tick();
        start_run(1000);
        for (int r = 0; r < 300; r++) begin
            Channels = 4'b0011; tick(); Channels = '0; tick();
        end
        wait_valid(600, "sat");
        chk("sat_counts", 64'(Counts[7:0]), 64'd255);
        chk("sat_ovf", 64'(Overflow), 64'h1);
        chk("sat_singles", 64'(Singles), 64'h0000_ffff);
        wait_valid(1100, "sat_next");
        chk("sat_next_counts", 64'(Counts), 64'h0);
        chk("sat_next_ovf", 64'(Overflow), 64'h0);
        Stop = 1; tick(); Stop = 0;
        wait_valid(1100, "sat_stop");

        // back-to-back periods, event on the final counting cycle
        repeat (3) tick();
        start_run(10);
        repeat (8) tick();
        Channels = 4'b0011; tick(); Channels = '0;
        wait_valid(20, "b2b_1");
        chk("b2b_first", 64'(Counts), 64'h1);
        chk("b2b_first_s", 64'(Singles), 64'h0000_0101);
        wait_valid(20, "b2b_2");
        chk("b2b_second", 64'(Counts), 64'h0);
        chk("b2b_busy", 64'(Busy), 64'd1);
        tick(); tick();
        Stop = 1; tick(); Stop = 0;
        wait_valid(20, "b2b_stop");
        tick();
        chk("stop_busy", 64'(Busy), 64'd0);
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Counts_valid === 1'b1) strobes++;
        end
        chk("no_more_strobes", 64'(strobes), 64'd0);
        Period = '0; Start = 1; tick(); Start = 0; tick();
        chk("period0_idle", 64'(Busy), 64'd0);

        // randomised episodes; configuration only changes once idle and flushed
        for (int ep = 0; ep < 25; ep++) begin
            Stop = 1; Start = 0; Channels = '0;
            idle_seen = 0;
            for (int i = 0; i < 200 && !idle_seen; i++) begin
                tick();
                if (Busy === 1'b0) idle_seen = 1;
            end
            if (!idle_seen) begin
                n_cmp++; n_fail++;
                $display("FAIL idle_wait: Busy still high in episode %0d", ep);
            end
            Stop = 0;
            repeat (20) tick();
            Delays = NCHAN*NBITS'($urandom);
            Window = WBITS'($urandom_range(0, 7));
            Period = TBITS'($urandom_range(1, 40));
            for (int cyc = 0; cyc < 150; cyc++) begin
                Channels = NCHAN'($urandom & $urandom);
                Start = ($urandom_range(0, 15) == 0);
                Stop  = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    Rst_n = 0; tick(); Rst_n = 1;
                end
                tick();
            end
            Start = 0; Stop = 0;
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic k_init();
        int k = 0;
        for (int a = 0; a < NCHAN; a++)
            for (int b = a + 1; b < NCHAN; b++) begin
                pa[k] = a; pb[k] = b; k++;
            end
    endtask

endmodule
